tdm_demux1to4: RTL and testbench
================================

Name: tdm_demux1to4

Overview:
- Receive end of a 4-slot time-division-multiplexed link. The far end uses a 4-to-1 mux whose select (s1,s0) walks slots w,x,y,z in order.
- This block takes the serial sample stream and a frame-sync marker, tracks the slot position, and rebuilds the four parallel channels.
- It presents the four channels as registered outputs and pulses frame_valid once per complete frame.
- It sits between the serial link and the consumers of the parallel channels.

Parameters:
- WIDTH, 1, bit width of each sample and of each of w, x, y, z.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample strobe; din and sync are accepted only on cycles with en=1.
- sync  input  1  qualified by en; marks the accepted sample as slot 0 (w).
- din  input  WIDTH  serial sample.
- w  output  WIDTH  channel 0, registered.
- x  output  WIDTH  channel 1, registered.
- y  output  WIDTH  channel 2, registered.
- z  output  WIDTH  channel 3, registered.
- s1  output  1  MSB of the slot index expected for the next accepted sample.
- s0  output  1  LSB of that slot index.
- frame_valid  output  1  one-cycle pulse; w..z have just updated.
- sync_err  output  1  one-cycle pulse; sync arrived mid-frame.

Behaviour:
- Reset (rst=1 at an edge, overrides everything): w,x,y,z=0; s1,s0=00; frame_valid=0; sync_err=0; locked=0; shadow regs=0.
- Internal state: 2-bit slot counter cnt, shown on {s1,s0}; locked flag; shadow regs sh0..sh2 (WIDTH each).
- States: UNLOCKED (locked=0) and LOCKED (locked=1).
- UNLOCKED, en=1, sync=0: sample discarded, cnt stays 00, no pulses.
- UNLOCKED, en=1, sync=1: sh0<=din, cnt<=01, locked<=1.
- LOCKED, en=1, sync=0, cnt in 0..2: sh[cnt]<=din, cnt<=cnt+1.
- LOCKED, en=1, sync=0, cnt=3:
  - w<=sh0, x<=sh1, y<=sh2, z<=din, all on the same edge;
  - frame_valid=1 for the following cycle;
  - cnt wraps to 00.
  - Sync is optional on later frames; the counter free-runs while locked.
- LOCKED, en=1, sync=1, cnt=00: normal slot-0 capture, same as sync=0.
- LOCKED, en=1, sync=1, cnt!=00:
  - partial frame discarded; w..z unchanged; no frame_valid;
  - sync_err=1 for the following cycle;
  - sh0<=din, cnt<=01 (resynchronise onto the new frame).
- en=0: all state holds; frame_valid and sync_err are 0 that cycle. Gaps of any length between samples are legal.
- Latency: the slot-3 sample appears on z, with frame_valid=1, one clock after the edge that accepts it.
- frame_valid and sync_err are never high together. Maximum frame_valid rate is one per 4 accepted samples.
- Reset mid-frame discards the partial frame and drops lock; a new sync is required to relock.

Decomposition:
- Shared package tdm_pkg holds:
  - SLOT_W=2'd0, SLOT_X=2'd1, SLOT_Y=2'd2, SLOT_Z=2'd3;
  - SLOT_CNT_W=2;
  - a slot_t typedef.
- One natural sub-module, tdm_slot_tracker: owns cnt, the locked flag and the sync_err logic. It outputs cnt, capture enable and frame-complete strobe.
- tdm_demux1to4 holds the shadow registers and output registers.

Test Plan:
- Reset: assert rst with random din/sync/en -> w=x=y=z=0, {s1,s0}=00, frame_valid=0, sync_err=0.
- Pre-lock: en=1, sync=0, din=1,1,1 -> no frame_valid, {s1,s0} stays 00, outputs stay 0.
- Lock and frame: en=1, din=1,0,1,0 with sync on the first sample -> {s1,s0} steps 01,10,11,00; then w=1,x=0,y=1,z=0 and frame_valid=1 for exactly one cycle. With WIDTH=4 and din=A,B,C,D -> w=A,x=B,y=C,z=D.
- Free-run plus gaps: after lock, send din=0,1,0,1 without sync, with en=0 gap cycles between samples -> w=0,x=1,y=0,z=1; one frame_valid; state held during gaps.
- Mid-frame sync: after 2 accepted samples, sync=1 with din=1, then 0,0,1 -> sync_err one-cycle pulse; no frame_valid for the partial frame; next frame_valid gives w=1,x=0,y=0,z=1.
- Reset mid-frame: rst after 2 samples, then 4 samples without sync -> outputs 0, no frame_valid (UNLOCKED); a sync frame afterwards locks normally.

Source files
------------

// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_pkg
// Description : Shared slot encodings and types for the 4-slot TDM receiver.
// Revision    : 1.0
// ============================================================================
package tdm_pkg;

    localparam int SLOT_CNT_W = 2;

    typedef logic [SLOT_CNT_W-1:0] slot_t;

    localparam slot_t SLOT_W = 2'd0;
    localparam slot_t SLOT_X = 2'd1;
    localparam slot_t SLOT_Y = 2'd2;
    localparam slot_t SLOT_Z = 2'd3;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tdm_slot_tracker
// Description : Slot counter, lock flag and mid-frame sync error detection.
// Revision    : 1.0
// ============================================================================
module tdm_slot_tracker
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_en,
    input  logic  i_sync,
    output slot_t o_cnt,
    output logic  o_capture,
    output slot_t o_capture_slot,
    output logic  o_frame_done,
    output logic  o_sync_err
);

    slot_t r_cnt;
    logic  r_locked;
    logic  r_sync_err;

    logic  w_resync;
    logic  w_normal;
    logic  w_err;

    // A sync restarts the frame unless it lands exactly on slot 0 while locked.
    assign w_resync = i_en & i_sync & (~r_locked | (r_cnt != SLOT_W));
    assign w_err    = w_resync & r_locked;
    assign w_normal = i_en & r_locked & ~w_resync;

    assign o_frame_done   = w_normal & (r_cnt == SLOT_Z);
    assign o_capture      = w_resync | (w_normal & (r_cnt != SLOT_Z));
    assign o_capture_slot = w_resync ? SLOT_W : r_cnt;
    assign o_cnt          = r_cnt;
    assign o_sync_err     = r_sync_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= SLOT_W;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_err;
            if (w_resync) begin
                r_cnt    <= SLOT_X;
                r_locked <= 1'b1;
            end else if (w_normal) begin
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdm_demux1to4.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux1to4
// Description : 4-slot TDM receiver; rebuilds w,x,y,z from a serial stream.
// Revision    : 1.0
// ============================================================================
module tdm_demux1to4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic             s1,
    output logic             s0,
    output logic             frame_valid,
    output logic             sync_err
);

    slot_t w_cnt;
    logic  w_capture;
    slot_t w_capture_slot;
    logic  w_frame_done;

    logic [WIDTH-1:0] r_sh0;
    logic [WIDTH-1:0] r_sh1;
    logic [WIDTH-1:0] r_sh2;

    tdm_slot_tracker u_tracker (
        .clk            (clk),
        .rst            (rst),
        .i_en           (en),
        .i_sync         (sync),
        .o_cnt          (w_cnt),
        .o_capture      (w_capture),
        .o_capture_slot (w_capture_slot),
        .o_frame_done   (w_frame_done),
        .o_sync_err     (sync_err)
    );

    assign s1 = w_cnt[1];
    assign s0 = w_cnt[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh0       <= '0;
            r_sh1       <= '0;
            r_sh2       <= '0;
            w           <= '0;
            x           <= '0;
            y           <= '0;
            z           <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= w_frame_done;
            if (w_capture) begin
                case (w_capture_slot)
                    SLOT_W:  r_sh0 <= din;
                    SLOT_X:  r_sh1 <= din;
                    default: r_sh2 <= din;
                endcase
            end
            // Slot 3 goes straight to z so all four channels update together.
            if (w_frame_done) begin
                w <= r_sh0;
                x <= r_sh1;
                y <= r_sh2;
                z <= din;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux1to4.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux1to4
// Description : Self-checking bench for tdm_demux1to4 against a frame model.
// Revision    : 1.0
// ============================================================================
module tb_tdm_demux1to4;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             sync;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] w, x, y, z;
    logic             s1, s0, frame_valid, sync_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: position in frame and samples collected so far.
    bit               m_locked;
    int               m_pos;
    logic [WIDTH-1:0] m_buf[$];
    logic [WIDTH-1:0] m_out[4];
    bit               m_fv;
    bit               m_err;
    int               fv_count;

    tdm_demux1to4 #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sync        (sync),
        .din         (din),
        .w           (w),
        .x           (x),
        .y           (y),
        .z           (z),
        .s1          (s1),
        .s0          (s0),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic s,
                              input logic [WIDTH-1:0] d);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (r) begin
            m_locked = 1'b0;
            m_pos    = 0;
            m_buf.delete();
            for (int i = 0; i < 4; i++) m_out[i] = '0;
        end else if (e) begin
            if (s && (!m_locked || m_pos != 0)) begin
                m_err = m_locked;
                m_buf.delete();
                m_buf.push_back(d);
                m_pos    = 1;
                m_locked = 1'b1;
            end else if (m_locked) begin
                m_buf.push_back(d);
                m_pos = (m_pos + 1) % 4;
                if (m_pos == 0) begin
                    for (int i = 0; i < 4; i++) m_out[i] = m_buf[i];
                    m_fv = 1'b1;
                    m_buf.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        logic [1:0] exp_slot;
        exp_slot = m_pos[1:0];
        chk("w", 32'(w), 32'(m_out[0]));
        chk("x", 32'(x), 32'(m_out[1]));
        chk("y", 32'(y), 32'(m_out[2]));
        chk("z", 32'(z), 32'(m_out[3]));
        chk("slot", 32'({s1, s0}), 32'(exp_slot));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("sync_err", 32'(sync_err), 32'(m_err));
        chk("fv_err_excl", 32'(frame_valid & sync_err), 32'd0);
        if (frame_valid) fv_count++;
    endtask

    task automatic cycle(input logic r, input logic e, input logic s,
                         input logic [WIDTH-1:0] d);
        @(negedge clk);
        rst  = r;
        en   = e;
        sync = s;
        din  = d;
        @(posedge clk);
        model_edge(r, e, s, d);
        #1;
        check_all();
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'($urandom), WIDTH'($urandom));
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        sync = 1'b0;
        din  = '0;
        m_locked = 1'b0;
        m_pos    = 0;
        fv_count = 0;
        for (int i = 0; i < 4; i++) m_out[i] = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom), 1'($urandom), WIDTH'($urandom));
        chk("rst_w", 32'(w), 32'd0);
        chk("rst_slot", 32'({s1, s0}), 32'd0);

        // Pre-lock samples are discarded
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 4'h1);
        chk("prelock_slot", 32'({s1, s0}), 32'd0);
        chk("prelock_fv", 32'(fv_count), 32'd0);

        // Lock and frame 1,0,1,0
        cycle(1'b0, 1'b1, 1'b1, 4'h1);
        chk("lock_s01", 32'({s1, s0}), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 4'h0);
        chk("lock_s10", 32'({s1, s0}), 32'd2);
        cycle(1'b0, 1'b1, 1'b0, 4'h1);
        chk("lock_s11", 32'({s1, s0}), 32'd3);
        cycle(1'b0, 1'b1, 1'b0, 4'h0);
        chk("lock_fv", 32'(frame_valid), 32'd1);
        chk("lock_wxyz", 32'({w, x, y, z}), 32'h1010);
        gap(1);
        chk("lock_fv_once", 32'(frame_valid), 32'd0);

        // Free-running wide frame A,B,C,D
        cycle(1'b0, 1'b1, 1'b0, 4'hA);
        cycle(1'b0, 1'b1, 1'b0, 4'hB);
        cycle(1'b0, 1'b1, 1'b0, 4'hC);
        cycle(1'b0, 1'b1, 1'b0, 4'hD);
        chk("wide_wxyz", 32'({w, x, y, z}), 32'hABCD);

        // Free-run with gaps: 0,1,0,1
        fv_count = 0;
        cycle(1'b0, 1'b1, 1'b0, 4'h0); gap(2);
        chk("gap_hold", 32'({s1, s0}), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 4'h1); gap(3);
        cycle(1'b0, 1'b1, 1'b0, 4'h0); gap(1);
        cycle(1'b0, 1'b1, 1'b0, 4'h1); gap(2);
        chk("gap_wxyz", 32'({w, x, y, z}), 32'h0101);
        chk("gap_fv_count", 32'(fv_count), 32'd1);

        // Mid-frame sync: two samples then resync frame 1,0,0,1
        fv_count = 0;
        cycle(1'b0, 1'b1, 1'b0, 4'h7);
        cycle(1'b0, 1'b1, 1'b0, 4'h7);
        cycle(1'b0, 1'b1, 1'b1, 4'h1);
        chk("midsync_err", 32'(sync_err), 32'd1);
        chk("midsync_slot", 32'({s1, s0}), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 4'h0);
        chk("midsync_err_once", 32'(sync_err), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 4'h0);
        cycle(1'b0, 1'b1, 1'b0, 4'h1);
        chk("midsync_wxyz", 32'({w, x, y, z}), 32'h1001);
        chk("midsync_fv_count", 32'(fv_count), 32'd1);

        // Reset mid-frame drops lock
        cycle(1'b0, 1'b1, 1'b0, 4'h3);
        cycle(1'b0, 1'b1, 1'b0, 4'h3);
        cycle(1'b1, 1'b1, 1'b0, 4'h3);
        fv_count = 0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 4'h5);
        chk("rstmid_fv", 32'(fv_count), 32'd0);
        chk("rstmid_wxyz", 32'({w, x, y, z}), 32'h0000);
        cycle(1'b0, 1'b1, 1'b1, 4'h2);
        cycle(1'b0, 1'b1, 1'b0, 4'h4);
        cycle(1'b0, 1'b1, 1'b0, 4'h6);
        cycle(1'b0, 1'b1, 1'b0, 4'h8);
        chk("relock_wxyz", 32'({w, x, y, z}), 32'h2468);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 199) == 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 9) == 0),
                  WIDTH'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
